// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding req/ack data-memory stage; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  whb_i,
  input  logic        su_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e      state_q;
  logic        req_q, we_q, done_q, su_q;
  logic [1:0]  lo_q, whb_q;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, wdata_q, rdata_q, wdata_d, rdata_d;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        acc, is_b, is_h;
  assign acc = state_q == IDLE && (mem_rd_i || mem_wr_i);
  assign is_b = whb_i == 2'b00;
  assign is_h = whb_i == 2'b01;
  assign be_d = is_b ? 4'b0001 << addr_i[1:0] : is_h ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_d = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
  assign lb = dmem_rdata_i[{lo_q, 3'b000} +: 8];
  assign lh = lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  assign rdata_d = whb_q == 2'b00 ? {{24{su_q & lb[7]}}, lb} :
                   whb_q == 2'b01 ? {{16{su_q & lh[15]}}, lh} : dmem_rdata_i;
  assign stall_o = !rst && (state_q == REQ || acc);
  assign done_o = done_q;
  assign rdata_o = rdata_q;
  assign dmem_req_o = req_q;
  assign dmem_we_o = we_q;
  assign dmem_addr_o = addr_q;
  assign dmem_be_o = be_q;
  assign dmem_wdata_o = wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis, mis_q;
  assign mis = is_h ? addr_i[0] : !is_b && addr_i[1:0] != 2'b00;
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif
  // FSM with registered bus and result outputs; bus fields are latched once at accept
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      su_q <= 1'b0;
      lo_q <= 2'b00;
      whb_q <= 2'b00;
      be_q <= 4'b0000;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
      case (state_q)
        IDLE: if (acc) begin
          we_q <= mem_wr_i;
          addr_q <= {addr_i[31:2], 2'b00};
          be_q <= be_d;
          wdata_q <= wdata_d;
          lo_q <= addr_i[1:0];
          whb_q <= whb_i;
          su_q <= su_i;
`ifdef LSU_MISALIGN_TRAP_EN
          if (mis) begin
            state_q <= RESP;
            done_q <= 1'b1;
            mis_q <= 1'b1;
          end else begin
            state_q <= REQ;
            req_q <= 1'b1;
          end
`else
          state_q <= REQ;
          req_q <= 1'b1;
`endif
        end
        REQ: if (dmem_ack_i) begin
          req_q <= 1'b0;
          done_q <= 1'b1;
          state_q <= RESP;
          if (!we_q) rdata_q <= rdata_d;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
